memio_responder: RTL and testbench
==================================

Name: memio_responder

Overview:
- Responder end of the processor memory interface: accepts load/store requests from the MIPS datapath (mem_addr / mem_writedata / mem_readdata) and returns data with a ready handshake.
- Decodes the address to one of: data RAM, screen RAM (shared with the VGA scan-out reader), or I/O registers (keyboard, LEDs, status).
- Sits between the datapath and the VGA/peripheral subsystem.

Parameters:
- DNloc, 64, data RAM depth in 32-bit words
- SNloc, 1200, screen RAM depth in character cells
- SBits, 8, screen cell width (character code)
- Dbits, 32, CPU data width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mem_req  in  1  CPU request; held high with stable addr/data until mem_ready
- mem_wr  in  1  1 = store, 0 = load
- mem_addr  in  32  byte address; bits [1:0] ignored
- mem_writedata  in  Dbits  store data
- mem_readdata  out  Dbits  load data, valid only while mem_ready=1
- mem_ready  out  1  one-cycle completion pulse
- vga_req  in  1  VGA scan-out read strobe
- vga_addr  in  $clog2(SNloc)  screen cell index
- vga_data  out  SBits  screen cell, registered, valid the cycle after vga_req
- key_code  in  8  keyboard scan code
- key_strobe  in  1  one-cycle pulse: key_code valid
- leds  out  16  LED register

Behaviour:
- Clock is clk; reset is synchronous and active-high. Reset forces: state IDLE, mem_ready=0, mem_readdata=0, vga_data=0, leds=0, key_valid=0, key register=0. RAM contents are not cleared. Reset mid-transaction abandons it; no write is committed after the reset edge.
- Address map (word aligned):
  - 0x1001_0000 + 4*i, i<DNloc: data RAM.
  - 0x1002_0000 + 4*i, i<SNloc: screen RAM. Store keeps writedata[SBits-1:0]; load zero-extends.
  - 0x1003_0000: key register (R); a load also clears key_valid.
  - 0x1003_0004: leds (R/W, low 16 bits; load zero-extends).
  - 0x1003_0008: status (R); bit0 = key_valid, other bits 0.
  - Anything else: store ignored, load returns 0, normal handshake (no hang).
- FSM:
  - IDLE: if mem_req, latch addr/wr/data and the decoded target; go to ACCESS.
  - ACCESS, target data RAM or I/O: commit the store or register the load data; go to RESP.
  - ACCESS, target screen RAM: if vga_req is high this cycle, stay in ACCESS (VGA has absolute priority); else commit or read; go to RESP.
  - RESP: mem_ready=1 with mem_readdata valid; go to IDLE.
- Latency:
  - req first high in cycle n -> mem_ready in cycle n+2 (no contention).
  - Screen access: n+2 plus one cycle per contended vga_req cycle.
- The requester must drop mem_req, or change to a new request, in the cycle after mem_ready. A req seen in IDLE is always a new transaction.
- During stores, mem_readdata is 0 when mem_ready=1.
- VGA port: vga_data <= screen[vga_addr] every cycle vga_req=1; it holds otherwise. Out-of-range vga_addr returns 0. A same-cycle CPU store to the same cell is deferred, so VGA reads the old value.
- Keyboard:
  - key_strobe latches key_code and sets key_valid.
  - If key_strobe coincides with the clearing key-register load commit, the strobe wins: key_valid stays 1 with the new code. The load returns the old code.
- Single outstanding transaction; no pipelining of CPU requests.

Optional Feature:
- Macro: MEMIO_STATS_EN.
- Defined:
  - Adds a 32-bit saturating counter at 0x1003_000C. It counts cycles spent in ACCESS stalled by vga_req.
  - A load returns the count. Any store clears it. Reset clears it.
  - Saturates at 0xFFFF_FFFF; no wrap.
- Undefined: 0x1003_000C behaves as unmapped (load returns 0, store ignored). No counter logic is synthesised.

Test Plan:
- Store 0xDEADBEEF to 0x1001_0008, then load the same address -> each mem_ready arrives 2 cycles after req; load returns 0xDEADBEEF. Reload after reset -> still 0xDEADBEEF.
- Store 0x0000_0141 to 0x1002_0000 (cell 0) with vga_req held high for 3 cycles from ACCESS entry -> mem_ready delayed by 3 cycles (cycle n+5). Then vga_req with vga_addr=0 -> vga_data=0x41 next cycle.
- key_strobe with key_code=0x1C, then load 0x1003_0008 -> 1. Load 0x1003_0000 -> 0x1C, then status -> 0. Repeat with key_strobe coinciding with the clear -> status stays 1.
- Store 0x1234_ABCD to 0x1003_0004 -> leds=0xABCD after the RESP cycle; load returns 0x0000_ABCD. Assert reset mid-ACCESS of a second store -> leds=0, mem_ready never pulses.
- Load 0x2000_0000 (unmapped) -> mem_ready at n+2, mem_readdata=0. Store to the same address -> no state change.
- With MEMIO_STATS_EN: 3 contended cycles, then load 0x1003_000C -> 3. Store 0 to it, reload -> 0. Without the macro -> load returns 0.

Source files
------------

// File: rtl/memio_responder.sv
// Responder for the CPU memory interface: data RAM, VGA-shared screen RAM and I/O registers.
// Optional MEMIO_STATS_EN adds a VGA-contention cycle counter at 0x1003_000C.
module memio_responder #(
  parameter int DNloc = 64,
  parameter int SNloc = 1200,
  parameter int SBits = 8,
  parameter int Dbits = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_req,
  input  logic                     mem_wr,
  input  logic [31:0]              mem_addr,
  input  logic [Dbits-1:0]         mem_writedata,
  output logic [Dbits-1:0]         mem_readdata,
  output logic                     mem_ready,
  input  logic                     vga_req,
  input  logic [$clog2(SNloc)-1:0] vga_addr,
  output logic [SBits-1:0]         vga_data,
  input  logic [7:0]               key_code,
  input  logic                     key_strobe,
  output logic [15:0]              leds,
  output logic [1:0]               fsm_state
);

  localparam int DAW = $clog2(DNloc);
  localparam int SAW = $clog2(SNloc);
  localparam int IW  = (SAW > DAW) ? SAW : DAW;

  // Handshake: mem_req is held with stable addr/data until the one-cycle
  // mem_ready pulse; the requester drops or replaces it the following cycle.
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef enum logic [2:0] {
    T_NONE, T_DRAM, T_SCREEN, T_KEY, T_LEDS, T_STATUS, T_STATS
  } target_t;

  state_t  state, state_next;
  target_t dec_target, cur_target;
  logic              cur_wr;
  logic [IW-1:0]     cur_idx;
  logic [Dbits-1:0]  cur_wdata;
  logic [Dbits-1:0]  load_data;
  logic [7:0]        key_q;
  logic              key_valid;
  logic              screen_stall;
  logic              commit;
  logic              unused_bits;

  logic [Dbits-1:0]  dram   [0:DNloc-1];
  logic [SBits-1:0]  screen [0:SNloc-1];

  assign unused_bits = ^mem_addr[1:0];

  always_comb begin
    dec_target = T_NONE;
    if (mem_addr[31:16] == 16'h1001 && 32'(mem_addr[15:2]) < DNloc) begin
      dec_target = T_DRAM;
    end else if (mem_addr[31:16] == 16'h1002 && 32'(mem_addr[15:2]) < SNloc) begin
      dec_target = T_SCREEN;
    end else if (mem_addr[31:4] == 28'h1003000) begin
      case (mem_addr[3:2])
        2'd0:    dec_target = T_KEY;
        2'd1:    dec_target = T_LEDS;
        2'd2:    dec_target = T_STATUS;
`ifdef MEMIO_STATS_EN
        2'd3:    dec_target = T_STATS;
`endif
        default: dec_target = T_NONE;
      endcase
    end
  end

  // VGA owns the screen RAM whenever it strobes, so the CPU waits in ACCESS.
  assign screen_stall = (state == ACCESS) && (cur_target == T_SCREEN) && vga_req;
  assign commit       = (state == ACCESS) && !screen_stall;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_req) state_next = ACCESS;
      ACCESS:  if (commit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef MEMIO_STATS_EN
  logic [31:0] stats_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stats_cnt <= '0;
    end else if (commit && cur_wr && cur_target == T_STATS) begin
      stats_cnt <= '0;
    end else if (screen_stall && stats_cnt != 32'hFFFF_FFFF) begin
      stats_cnt <= stats_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    load_data = '0;
    case (cur_target)
      T_DRAM:   load_data = dram[cur_idx[DAW-1:0]];
      T_SCREEN: load_data[SBits-1:0] = screen[cur_idx[SAW-1:0]];
      T_KEY:    load_data[7:0] = key_q;
      T_LEDS:   load_data[15:0] = leds;
      T_STATUS: load_data[0] = key_valid;
`ifdef MEMIO_STATS_EN
      T_STATS:  load_data[31:0] = stats_cnt;
`endif
      default:  load_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cur_target   <= T_NONE;
      cur_wr       <= 1'b0;
      cur_idx      <= '0;
      cur_wdata    <= '0;
      mem_readdata <= '0;
      vga_data     <= '0;
      leds         <= '0;
      key_q        <= '0;
      key_valid    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && mem_req) begin
        cur_target <= dec_target;
        cur_wr     <= mem_wr;
        cur_idx    <= mem_addr[IW+1:2];
        cur_wdata  <= mem_writedata;
      end
      if (commit) begin
        mem_readdata <= cur_wr ? '0 : load_data;
      end
      if (commit && cur_wr && cur_target == T_LEDS) begin
        leds <= cur_wdata[15:0];
      end
      if (vga_req) begin
        vga_data <= (32'(vga_addr) < SNloc) ? screen[vga_addr] : '0;
      end
      // A new keystroke outranks the clear from a concurrent key-register load.
      if (key_strobe) begin
        key_q     <= key_code;
        key_valid <= 1'b1;
      end else if (commit && !cur_wr && cur_target == T_KEY) begin
        key_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && commit && cur_wr && cur_target == T_DRAM) begin
      dram[cur_idx[DAW-1:0]] <= cur_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && commit && cur_wr && cur_target == T_SCREEN) begin
      screen[cur_idx[SAW-1:0]] <= cur_wdata[SBits-1:0];
    end
  end

  assign mem_ready = (state == RESP);
  assign fsm_state = state;

endmodule

// File: tb/tb_memio_responder.sv
// Directed bench for memio_responder: driver tasks push expected responses,
// a negedge monitor pops and compares them whenever mem_ready pulses.
module tb_memio_responder;
  localparam int DW  = 32;
  localparam int SAW = $clog2(1200);

  logic           clk = 1'b0;
  logic           reset;
  logic           mem_req;
  logic           mem_wr;
  logic [31:0]    mem_addr;
  logic [DW-1:0]  mem_writedata;
  logic [DW-1:0]  mem_readdata;
  logic           mem_ready;
  logic           vga_req;
  logic [SAW-1:0] vga_addr;
  logic [7:0]     vga_data;
  logic [7:0]     key_code;
  logic           key_strobe;
  logic [15:0]    leds;
  logic [1:0]     fsm_state;

  memio_responder dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_ready(mem_ready),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data),
    .key_code(key_code), .key_strobe(key_strobe), .leds(leds), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  int            lat_q[$];
  int            iss_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (mem_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ready: mem_ready=1 at cycle %0d with nothing outstanding", cyc);
      end else begin
        logic [DW-1:0] e;
        int l, s;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        s = iss_q.pop_front();
        n_checks++;
        if (mem_readdata !== e) begin
          n_errors++;
          $display("FAIL readdata: got %h expected %h", mem_readdata, e);
        end
        n_checks++;
        if (cyc - s != l) begin
          n_errors++;
          $display("FAIL latency: got %0d expected %0d", cyc - s, l);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: starts and returns just after a rising edge
  task automatic cpu_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] exp, input int lat);
    bit got;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    iss_q.push_back(cyc);
    mem_req       = 1'b1;
    mem_wr        = wr;
    mem_addr      = addr;
    mem_writedata = data;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mem_ready) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: no mem_ready for addr %h", addr);
      void'(exp_q.pop_back());
      void'(lat_q.pop_back());
      void'(iss_q.pop_back());
    end
    @(posedge clk);
    #1;
    mem_req = 1'b0;
  endtask

  task automatic key_pulse(input logic [7:0] code);
    key_code   = code;
    key_strobe = 1'b1;
    @(posedge clk);
    #1;
    key_strobe = 1'b0;
  endtask

  task automatic vga_read(input logic [SAW-1:0] a);
    vga_addr = a;
    vga_req  = 1'b1;
    @(posedge clk);
    #1;
    vga_req = 1'b0;
  endtask

  initial begin
    bit seen;
    reset = 1'b1; mem_req = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_writedata = '0;
    vga_req = 1'b0; vga_addr = '0; key_code = '0; key_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("reset_ready", {31'b0, mem_ready}, 32'h0);
    check("reset_readdata", mem_readdata, 32'h0);
    check("reset_vga_data", {24'b0, vga_data}, 32'h0);
    check("reset_leds", {16'b0, leds}, 32'h0);
    check("reset_state", {30'b0, fsm_state}, 32'h0);

    cpu_txn(1'b0, 32'h1003_0008, 32'h0, 32'h0, 2);

    // data RAM
    cpu_txn(1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0, 2);
    cpu_txn(1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 2);
    cpu_txn(1'b0, 32'h1001_000B, 32'h0, 32'hDEAD_BEEF, 2);
    cpu_txn(1'b1, 32'h1001_00FC, 32'h0123_4567, 32'h0, 2);
    cpu_txn(1'b0, 32'h1001_00FC, 32'h0, 32'h0123_4567, 2);
    cpu_txn(1'b0, 32'h1001_0100, 32'h0, 32'h0, 2);

    // screen store contended by VGA for three cycles from ACCESS entry
    fork
      cpu_txn(1'b1, 32'h1002_0000, 32'h0000_0141, 32'h0, 5);
      begin
        @(posedge clk);
        #1;
        vga_addr = 11'd5;
        vga_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vga_req = 1'b0;
      end
    join

    vga_read(11'd0);
    check("vga_cell0", {24'b0, vga_data}, 32'h41);
    @(posedge clk);
    #1;
    check("vga_hold", {24'b0, vga_data}, 32'h41);
    vga_read(11'd1500);
    check("vga_oob", {24'b0, vga_data}, 32'h0);

    cpu_txn(1'b0, 32'h1002_0000, 32'h0, 32'h41, 2);
    cpu_txn(1'b1, 32'h1002_12BC, 32'h0000_77A5, 32'h0, 2);
    cpu_txn(1'b0, 32'h1002_12BC, 32'h0, 32'hA5, 2);
    cpu_txn(1'b0, 32'h1002_12C0, 32'h0, 32'h0, 2);

`ifdef MEMIO_STATS_EN
    cpu_txn(1'b0, 32'h1003_000C, 32'h0, 32'd3, 2);
    cpu_txn(1'b1, 32'h1003_000C, 32'h0, 32'h0, 2);
    cpu_txn(1'b0, 32'h1003_000C, 32'h0, 32'h0, 2);
`else
    cpu_txn(1'b1, 32'h1003_000C, 32'hFFFF_FFFF, 32'h0, 2);
    cpu_txn(1'b0, 32'h1003_000C, 32'h0, 32'h0, 2);
`endif

    // keyboard
    key_pulse(8'h1C);
    cpu_txn(1'b0, 32'h1003_0008, 32'h0, 32'h1, 2);
    cpu_txn(1'b0, 32'h1003_0000, 32'h0, 32'h1C, 2);
    cpu_txn(1'b0, 32'h1003_0008, 32'h0, 32'h0, 2);
    fork
      cpu_txn(1'b0, 32'h1003_0000, 32'h0, 32'h1C, 2);
      begin
        @(posedge clk);
        #1;
        key_pulse(8'h33);
      end
    join
    cpu_txn(1'b0, 32'h1003_0008, 32'h0, 32'h1, 2);
    cpu_txn(1'b0, 32'h1003_0000, 32'h0, 32'h33, 2);
    cpu_txn(1'b0, 32'h1003_0008, 32'h0, 32'h0, 2);

    // LEDs
    cpu_txn(1'b1, 32'h1003_0004, 32'h1234_ABCD, 32'h0, 2);
    check("leds_after_store", {16'b0, leds}, 32'hABCD);
    cpu_txn(1'b0, 32'h1003_0004, 32'h0, 32'h0000_ABCD, 2);

    // unmapped
    cpu_txn(1'b0, 32'h2000_0000, 32'h0, 32'h0, 2);
    cpu_txn(1'b1, 32'h2000_0000, 32'hFFFF_FFFF, 32'h0, 2);
    check("leds_unmapped_store", {16'b0, leds}, 32'hABCD);
    cpu_txn(1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 2);

    // reset in the middle of a store
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 32'h1003_0004; mem_writedata = 32'h0000_5555;
    @(posedge clk);
    #1;
    check("state_access", {30'b0, fsm_state}, 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    mem_req = 1'b0;
    check("leds_after_reset", {16'b0, leds}, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_ready) seen = 1'b1;
    end
    check("no_ready_after_reset", {31'b0, seen}, 32'h0);
    @(posedge clk);
    #1;
    check("leds_still_zero", {16'b0, leds}, 32'h0);
    check("state_idle", {30'b0, fsm_state}, 32'h0);

    cpu_txn(1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 2);
    cpu_txn(1'b0, 32'h1002_0000, 32'h0, 32'h41, 2);
    cpu_txn(1'b0, 32'h1003_0008, 32'h0, 32'h0, 2);
`ifdef MEMIO_STATS_EN
    cpu_txn(1'b0, 32'h1003_000C, 32'h0, 32'h0, 2);
`endif

    repeat (4) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d responses outstanding", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
